acuity_test_ctrl: RTL

Parametrised control core for the visual-acuity tester, and the successor of the fixed single-trial descend-only logic inside `display`. It presents random optotype directions at a current acuity level and scores the five debounced keys. Each level runs N trials with a pass threshold and an answer timeout. It supports descend-only or up/down staircase mode and reports a final level or a fail ("X"). It drives the existing matrix and seven-segment renderers through `level`, `dir` and `show`.

---
 rtl/acuity_test_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/acuity_test_ctrl.sv
// Control core for the visual-acuity tester: presents random optotype directions per level,
// scores debounced answer keys, and walks levels in descend-only or staircase mode.
module acuity_test_ctrl #(
  parameter int         NUM_LEVELS       = 5,
  parameter int         LVL_W            = 3,
  parameter int         START_LEVEL      = 4,
  parameter int         TRIALS_PER_LEVEL = 3,
  parameter int         PASS_COUNT       = 2,
  parameter int         MODE             = 0,
  parameter int         TIMEOUT_CYC      = 5_000_000,
  parameter int         TO_W             = 23,
  parameter logic [7:0] LFSR_SEED        = 8'hA5
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             key_restart,
  input  logic             key_up,
  input  logic             key_right,
  input  logic             key_down,
  input  logic             key_left,
  output logic [LVL_W-1:0] level,
  output logic [1:0]       dir,
  output logic             show,
  output logic [3:0]       trial,
  output logic             busy,
  output logic             result_valid,
  output logic [LVL_W-1:0] result_level,
  output logic             result_fail
);

  typedef enum logic [1:0] {IDLE, PRESENT, EVAL, DONE} state_t;

  localparam logic [LVL_W-1:0] START_LVL = LVL_W'(START_LEVEL);
  localparam logic [LVL_W-1:0] TOP_LVL   = LVL_W'(NUM_LEVELS - 1);
  localparam logic [3:0]       PASS_N    = 4'(PASS_COUNT);
  localparam logic [3:0]       MISS_LIM  = 4'(TRIALS_PER_LEVEL - PASS_COUNT);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  state_t          state;
  logic [4:0]      key_cur;
  logic [4:0]      key_prev;
  logic [4:0]      key_edge;
  logic [3:0]      dir_edges;
  logic            restart_edge;
  logic [7:0]      lfsr;
  logic [3:0]      hits;
  logic [3:0]      misses;
  logic            dropped;
  logic            passed_below;
  logic            answer_ok;
  logic [TO_W-1:0] to_cnt;

  logic            one_edge;
  logic            key_match;
  logic            timed_out;
  logic [1:0]      next_dir;
  logic [3:0]      hits_nx;
  logic [3:0]      misses_nx;
  logic            lvl_pass;
  logic            lvl_fail;
  logic            ev_finish;
  logic            ev_fail;
  logic            ev_change;
  logic [LVL_W-1:0] ev_res_lvl;
  logic [LVL_W-1:0] ev_next_lvl;
  logic            ev_dropped;
  logic            ev_passed_below;

  // Key vector order: {restart, left, down, right, up}; bit index of a direction equals its dir code.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      key_cur  <= '0;
      key_prev <= '0;
    end else begin
      key_cur  <= {key_restart, key_left, key_down, key_right, key_up};
      key_prev <= key_cur;
    end
  end

  assign key_edge     = key_cur & ~key_prev;
  assign dir_edges    = key_edge[3:0];
  assign restart_edge = key_edge[4];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) lfsr <= LFSR_SEED;
    else         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  always_comb begin
    one_edge  = (dir_edges != 4'd0) && ((dir_edges & (dir_edges - 4'd1)) == 4'd0);
    key_match = (dir_edges & (4'b0001 << dir)) != 4'd0;
    timed_out = (TIMEOUT_CYC != 0) && (to_cnt == TO_LAST);
    next_dir  = (lfsr[1:0] == dir) ? lfsr[1:0] + 2'd1 : lfsr[1:0];
    hits_nx   = hits + {3'd0, answer_ok};
    misses_nx = misses + {3'd0, ~answer_ok};
    lvl_pass  = hits_nx >= PASS_N;
    lvl_fail  = misses_nx > MISS_LIM;
  end

  // Level-walk decision taken in EVAL; the staircase ends at the first reversal.
  always_comb begin
    ev_finish       = 1'b0;
    ev_fail         = 1'b0;
    ev_change       = 1'b0;
    ev_res_lvl      = level;
    ev_next_lvl     = level;
    ev_dropped      = dropped;
    ev_passed_below = passed_below;
    if (lvl_pass) begin
      if (MODE == 0 || dropped || level == TOP_LVL) begin
        ev_finish = 1'b1;
      end else begin
        ev_change       = 1'b1;
        ev_next_lvl     = level + LVL_W'(1);
        ev_passed_below = 1'b1;
      end
    end else if (lvl_fail) begin
      if (MODE != 0 && passed_below) begin
        ev_finish  = 1'b1;
        ev_res_lvl = level - LVL_W'(1);
      end else if (level == '0) begin
        ev_finish  = 1'b1;
        ev_fail    = 1'b1;
        ev_res_lvl = '0;
      end else begin
        ev_change   = 1'b1;
        ev_next_lvl = level - LVL_W'(1);
        if (MODE != 0) begin
          ev_dropped      = 1'b1;
          ev_passed_below = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= IDLE;
      level        <= START_LVL;
      dir          <= 2'b00;
      show         <= 1'b0;
      trial        <= 4'd0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_level <= '0;
      result_fail  <= 1'b0;
      hits         <= 4'd0;
      misses       <= 4'd0;
      dropped      <= 1'b0;
      passed_below <= 1'b0;
      answer_ok    <= 1'b0;
      to_cnt       <= '0;
    end else if (restart_edge) begin
      state        <= PRESENT;
      level        <= START_LVL;
      dir          <= next_dir;
      show         <= 1'b1;
      trial        <= 4'd0;
      busy         <= 1'b1;
      result_valid <= 1'b0;
      result_level <= '0;
      result_fail  <= 1'b0;
      hits         <= 4'd0;
      misses       <= 4'd0;
      dropped      <= 1'b0;
      passed_below <= 1'b0;
      to_cnt       <= '0;
    end else begin
      case (state)
        PRESENT: begin
          // A key edge and the timeout share one path so both reach EVAL with identical timing.
          if (dir_edges != 4'd0 || timed_out) begin
            state     <= EVAL;
            show      <= 1'b0;
            answer_ok <= one_edge && key_match;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        EVAL: begin
          if (ev_finish) begin
            state        <= DONE;
            busy         <= 1'b0;
            result_valid <= 1'b1;
            result_fail  <= ev_fail;
            result_level <= ev_res_lvl;
            trial        <= trial + 4'd1;
            hits         <= hits_nx;
            misses       <= misses_nx;
          end else begin
            state        <= PRESENT;
            show         <= 1'b1;
            dir          <= next_dir;
            to_cnt       <= '0;
            dropped      <= ev_dropped;
            passed_below <= ev_passed_below;
            if (ev_change) begin
              level  <= ev_next_lvl;
              trial  <= 4'd0;
              hits   <= 4'd0;
              misses <= 4'd0;
            end else begin
              trial  <= trial + 4'd1;
              hits   <= hits_nx;
              misses <= misses_nx;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
